// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU compute stage.
//   OP_ADD/OP_SUB/OP_MUL/OP_DIV : operator encodings on in_operator/operator
//   state_t                     : control FSM state of fpu_compute_iter
package fpu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fpu_seq_muldiv.sv
// Iterative multiply / divide datapath.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load operands and begin (single-cycle pulse)
//   mode       : 0 = multiply (MAN_W iterations), 1 = divide (2*MAN_W iterations)
//   opa, opb   : multiply: opa * opb ; divide: (opa << MAN_W) / opb
//   done       : high during the final iteration cycle
//   result     : value the final iteration produces (valid while done is high)
module fpu_seq_muldiv #(
  parameter int unsigned MAN_W = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic [MAN_W-1:0]     opa,
  input  logic [MAN_W-1:0]     opb,
  output logic                 done,
  output logic [2*MAN_W-1:0]   result
);

  localparam int unsigned CNT_W = $clog2(2 * MAN_W) + 1;

  // acc: multiply product register (multiplier in low half), or divide remainder in low half.
  // sh : divide dividend bits shifted out MSB first, quotient bits shifted in at the LSB.
  logic [2*MAN_W-1:0] acc;
  logic [2*MAN_W-1:0] sh;
  logic [MAN_W-1:0]   opnd;
  logic [CNT_W-1:0]   cnt;
  logic               busy;
  logic               mode_q;

  logic [MAN_W:0]     mul_sum;
  logic [2*MAN_W-1:0] mul_nxt;
  logic [MAN_W:0]     trial;
  logic [MAN_W:0]     diff;
  logic               fits;
  logic [MAN_W-1:0]   rem_nxt;
  logic [2*MAN_W-1:0] div_sh_nxt;

  always_comb begin
    // Shift-add: add the multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set, then shift the whole product right.
    mul_sum    = {1'b0, acc[2*MAN_W-1:MAN_W]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_nxt    = {mul_sum, acc[MAN_W-1:1]};
    // Restoring step: bring down next dividend bit, subtract divisor if it fits.
    trial      = {acc[MAN_W-1:0], sh[2*MAN_W-1]};
    fits       = (trial >= {1'b0, opnd});
    diff       = trial - {1'b0, opnd};
    rem_nxt    = fits ? diff[MAN_W-1:0] : trial[MAN_W-1:0];
    div_sh_nxt = {sh[2*MAN_W-2:0], fits};
    done       = busy && (cnt == CNT_W'(1));
    result     = mode_q ? div_sh_nxt : mul_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      sh     <= '0;
      opnd   <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      mode_q <= 1'b0;
    end else if (start) begin
      busy   <= 1'b1;
      mode_q <= mode;
      if (mode) begin
        cnt  <= CNT_W'(2 * MAN_W);
        opnd <= opb;
        acc  <= '0;
        sh   <= {opa, {MAN_W{1'b0}}};
      end else begin
        cnt  <= CNT_W'(MAN_W);
        opnd <= opa;
        acc  <= {{MAN_W{1'b0}}, opb};
        sh   <= '0;
      end
    end else if (busy) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) begin
        busy <= 1'b0;
      end
      if (mode_q) begin
        acc <= {{MAN_W{1'b0}}, rem_nxt};
        sh  <= div_sh_nxt;
      end else begin
        acc <= mul_nxt;
      end
    end
  end

endmodule

// File: rtl/fpu_compute_iter.sv
// FPU compute stage with valid/ready handshakes on both sides.
// Add/sub resolve in the accept cycle; mul/div run on fpu_seq_muldiv.
//   clk, rst_n                     : clock, asynchronous active-low reset
//   in_valid / in_ready            : operand handshake (in_ready only in IDLE)
//   in_sign_1/2, in_exponent,
//   in_mantissa_1/2, in_operator   : pre-aligned operands and operator
//   out_valid / out_ready          : result handshake
//   sign, exponent, mantissa,
//   operator, div_by_zero          : registered result, stable while out_valid
module fpu_compute_iter #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign_1,
  input  logic                 in_sign_2,
  input  logic [EXP_W-1:0]     in_exponent,
  input  logic [MAN_W-1:0]     in_mantissa_1,
  input  logic [MAN_W-1:0]     in_mantissa_2,
  input  logic [1:0]           in_operator,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sign,
  output logic [EXP_W-1:0]     exponent,
  output logic [2*MAN_W-1:0]   mantissa,
  output logic [1:0]           operator,
  output logic                 div_by_zero
);

  import fpu_pkg::*;

  state_t             state;
  logic               sb;
  logic [MAN_W:0]     as_mag;
  logic               as_sign;
  logic               m2_zero;
  logic               md_start;
  logic               md_done;
  logic [2*MAN_W-1:0] md_result;

  assign in_ready = (state == IDLE);
  assign m2_zero  = (in_mantissa_2 == '0);
  assign md_start = in_valid && in_ready && in_operator[1]
                    && !((in_operator == OP_DIV) && m2_zero);

  // Sign-magnitude add/sub; subtraction folds into an effective sign of operand 2.
  always_comb begin
    sb      = in_sign_2 ^ (in_operator == OP_SUB);
    as_mag  = '0;
    as_sign = 1'b0;
    if (in_sign_1 == sb) begin
      as_mag  = {1'b0, in_mantissa_1} + {1'b0, in_mantissa_2};
      as_sign = in_sign_1;
    end else if (in_mantissa_1 > in_mantissa_2) begin
      as_mag  = {1'b0, in_mantissa_1} - {1'b0, in_mantissa_2};
      as_sign = in_sign_1;
    end else if (in_mantissa_2 > in_mantissa_1) begin
      as_mag  = {1'b0, in_mantissa_2} - {1'b0, in_mantissa_1};
      as_sign = sb;
    end
  end

  fpu_seq_muldiv #(
    .MAN_W(MAN_W)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (md_start),
    .mode   (in_operator[0]),
    .opa    (in_mantissa_1),
    .opb    (in_mantissa_2),
    .done   (md_done),
    .result (md_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      sign        <= 1'b0;
      exponent    <= '0;
      mantissa    <= '0;
      operator    <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            exponent    <= in_exponent;
            operator    <= in_operator;
            div_by_zero <= 1'b0;
            sign        <= in_operator[1] ? (in_sign_1 ^ in_sign_2) : as_sign;
            case (in_operator)
              OP_ADD, OP_SUB: begin
                mantissa  <= {{(MAN_W-1){1'b0}}, as_mag};
                out_valid <= 1'b1;
                state     <= DONE;
              end
              OP_MUL: state <= MUL;
              default: begin
                if (m2_zero) begin
                  mantissa    <= '1;
                  div_by_zero <= 1'b1;
                  out_valid   <= 1'b1;
                  state       <= DONE;
                end else begin
                  state <= DIV;
                end
              end
            endcase
          end
        end
        MUL, DIV: begin
          if (md_done) begin
            mantissa  <= md_result;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_compute_iter.sv
module tb_fpu_compute_iter;

  localparam int EW  = 8;
  localparam int MW  = 24;
  localparam int MW2 = 2 * MW;
  localparam int RW  = 1 + EW + 2 + 1 + MW2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_sign_1 = 1'b0;
  logic            in_sign_2 = 1'b0;
  logic [EW-1:0]   in_exponent = '0;
  logic [MW-1:0]   in_mantissa_1 = '0;
  logic [MW-1:0]   in_mantissa_2 = '0;
  logic [1:0]      in_operator = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            sign;
  logic [EW-1:0]   exponent;
  logic [MW2-1:0]  mantissa;
  logic [1:0]      operator;
  logic            div_by_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fpu_compute_iter #(
    .EXP_W(EW),
    .MAN_W(MW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign_1    (in_sign_1),
    .in_sign_2    (in_sign_2),
    .in_exponent  (in_exponent),
    .in_mantissa_1(in_mantissa_1),
    .in_mantissa_2(in_mantissa_2),
    .in_operator  (in_operator),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sign         (sign),
    .exponent     (exponent),
    .mantissa     (mantissa),
    .operator     (operator),
    .div_by_zero  (div_by_zero)
  );

  // Reference result {sign, exponent, operator, div_by_zero, mantissa} from signed arithmetic.
  function automatic logic [RW-1:0] model(input bit s1, input bit s2, input logic [MW-1:0] m1,
                                          input logic [MW-1:0] m2, input logic [1:0] op,
                                          input logic [EW-1:0] e);
    longint a, b, r;
    bit sb, rs, dz;
    logic [MW2-1:0] rm;
    a  = longint'(m1);
    b  = longint'(m2);
    rs = 1'b0;
    dz = 1'b0;
    rm = '0;
    case (op)
      2'd0, 2'd1: begin
        sb = s2 ^ (op == 2'd1);
        r  = (s1 ? -a : a) + (sb ? -b : b);
        rs = (s1 == sb) ? s1 : (r < 0);
        rm = MW2'((r < 0) ? -r : r);
      end
      2'd2: begin
        rs = s1 ^ s2;
        rm = MW2'(a * b);
      end
      default: begin
        rs = s1 ^ s2;
        if (b == 0) begin
          rm = '1;
          dz = 1'b1;
        end else begin
          rm = MW2'((a <<< MW) / b);
        end
      end
    endcase
    return {rs, e, op, dz, rm};
  endfunction

  function automatic logic [RW-1:0] observed();
    return {sign, exponent, operator, div_by_zero, mantissa};
  endfunction

  // Issue one operation, scramble inputs while busy, wait (bounded) for out_valid.
  // lat counts clock edges from the accept edge (=1) to the edge that raised out_valid.
  task automatic run_op(input bit s1, input bit s2, input logic [MW-1:0] m1, input logic [MW-1:0] m2,
                        input logic [1:0] op, input logic [EW-1:0] e, input bit rdy,
                        output int lat, output bit busy_ok, output logic [RW-1:0] got);
    @(negedge clk);
    in_valid = 1'b1; in_sign_1 = s1; in_sign_2 = s2; in_mantissa_1 = m1;
    in_mantissa_2 = m2; in_operator = op; in_exponent = e; out_ready = rdy;
    @(posedge clk);
    lat = 1;
    busy_ok = 1'b1;
    #1;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      in_valid = 1'($urandom_range(0, 1));
      in_sign_1 = 1'($urandom_range(0, 1)); in_sign_2 = 1'($urandom_range(0, 1));
      in_mantissa_1 = MW'($urandom); in_mantissa_2 = MW'($urandom);
      in_operator = 2'($urandom_range(0, 3)); in_exponent = EW'($urandom);
      @(posedge clk);
      lat++;
      #1;
    end
    in_valid = 1'b0;
    if (out_valid !== 1'b1) lat = -1;
    got = observed();
    if (rdy) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #1;
    if ({out_valid, in_ready, observed()} !== {1'b0, 1'b1, {RW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_async: got %h required %h", {out_valid, in_ready, observed()}, {1'b0, 1'b1, {RW{1'b0}}});
    end
    checks++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    if ({out_valid, in_ready, observed()} !== {1'b0, 1'b1, {RW{1'b0}}}) begin
      errors++;
      $display("FAIL reset_idle: got %h required %h", {out_valid, in_ready, observed()}, {1'b0, 1'b1, {RW{1'b0}}});
    end
    checks++;
  endtask

  task automatic test_add();
    int lat; bit bok; logic [RW-1:0] got, exp;
    logic [MW-1:0] m1, m2; logic [1:0] op; logic [EW-1:0] e; bit s1, s2;
    run_op(1'b0, 1'b0, 24'hA00000, 24'hC00000, 2'b00, 8'h5A, 1'b1, lat, bok, got);
    if (got !== {1'b0, 8'h5A, 2'b00, 1'b0, 48'h000001600000} || lat != 1) begin
      errors++;
      $display("FAIL add_directed: got %h lat %0d required %h lat 1", got, lat, {1'b0, 8'h5A, 2'b00, 1'b0, 48'h000001600000});
    end
    checks++;
    for (int i = 0; i < 12; i++) begin
      s1 = 1'($urandom_range(0, 1)); s2 = 1'($urandom_range(0, 1));
      m1 = MW'($urandom); m2 = (i % 4 == 3) ? m1 : MW'($urandom);
      op = 2'($urandom_range(0, 1)); e = EW'($urandom);
      exp = model(s1, s2, m1, m2, op, e);
      run_op(s1, s2, m1, m2, op, e, 1'b1, lat, bok, got);
      if (got !== exp || lat != 1) begin
        errors++;
        $display("FAIL addsub_random[%0d]: got %h lat %0d required %h lat 1", i, got, lat, exp);
      end
      checks++;
    end
  endtask

  task automatic test_sub();
    int lat; bit bok; logic [RW-1:0] got;
    run_op(1'b0, 1'b0, 24'hAF0000, 24'h150000, 2'b01, 8'h11, 1'b1, lat, bok, got);
    if (got !== {1'b0, 8'h11, 2'b01, 1'b0, 48'h0000009A0000}) begin
      errors++;
      $display("FAIL sub_fwd: got %h required %h", got, {1'b0, 8'h11, 2'b01, 1'b0, 48'h0000009A0000});
    end
    checks++;
    run_op(1'b0, 1'b0, 24'h150000, 24'hAF0000, 2'b01, 8'h11, 1'b1, lat, bok, got);
    if (got !== {1'b1, 8'h11, 2'b01, 1'b0, 48'h0000009A0000}) begin
      errors++;
      $display("FAIL sub_swap: got %h required %h", got, {1'b1, 8'h11, 2'b01, 1'b0, 48'h0000009A0000});
    end
    checks++;
    run_op(1'b0, 1'b0, 24'hAF0000, 24'hAF0000, 2'b01, 8'h11, 1'b1, lat, bok, got);
    if (got !== {1'b0, 8'h11, 2'b01, 1'b0, 48'h0}) begin
      errors++;
      $display("FAIL sub_equal: got %h required %h", got, {1'b0, 8'h11, 2'b01, 1'b0, 48'h0});
    end
    checks++;
  endtask

  task automatic test_mul();
    int lat; bit bok; logic [RW-1:0] got, exp;
    logic [MW-1:0] m1, m2; logic [EW-1:0] e; bit s1, s2;
    run_op(1'b1, 1'b0, 24'hA00000, 24'hC00000, 2'b10, 8'h33, 1'b1, lat, bok, got);
    if (got !== {1'b1, 8'h33, 2'b10, 1'b0, 48'h780000000000} || lat != MW + 1 || !bok) begin
      errors++;
      $display("FAIL mul_directed: got %h lat %0d busy_ok %0d required %h lat %0d busy_ok 1",
               got, lat, bok, {1'b1, 8'h33, 2'b10, 1'b0, 48'h780000000000}, MW + 1);
    end
    checks++;
    for (int i = 0; i < 4; i++) begin
      s1 = 1'($urandom_range(0, 1)); s2 = 1'($urandom_range(0, 1));
      m1 = (i == 0) ? '1 : MW'($urandom); m2 = (i == 0) ? '1 : MW'($urandom); e = EW'($urandom);
      exp = model(s1, s2, m1, m2, 2'b10, e);
      run_op(s1, s2, m1, m2, 2'b10, e, 1'b1, lat, bok, got);
      if (got !== exp || lat != MW + 1) begin
        errors++;
        $display("FAIL mul_random[%0d]: got %h lat %0d required %h lat %0d", i, got, lat, exp, MW + 1);
      end
      checks++;
    end
  endtask

  task automatic test_div();
    int lat; bit bok; logic [RW-1:0] got, exp;
    logic [MW-1:0] m1, m2; logic [EW-1:0] e; bit s1, s2;
    run_op(1'b0, 1'b0, 24'hC00000, 24'h800000, 2'b11, 8'h44, 1'b1, lat, bok, got);
    if (got !== {1'b0, 8'h44, 2'b11, 1'b0, 48'h000001800000} || lat != 2 * MW + 1 || !bok) begin
      errors++;
      $display("FAIL div_directed: got %h lat %0d busy_ok %0d required %h lat %0d busy_ok 1",
               got, lat, bok, {1'b0, 8'h44, 2'b11, 1'b0, 48'h000001800000}, 2 * MW + 1);
    end
    checks++;
    run_op(1'b1, 1'b0, 24'hC00000, 24'h000000, 2'b11, 8'h44, 1'b1, lat, bok, got);
    if (got !== {1'b1, 8'h44, 2'b11, 1'b1, 48'hFFFFFFFFFFFF} || lat != 1) begin
      errors++;
      $display("FAIL div_by_zero: got %h lat %0d required %h lat 1", got, lat, {1'b1, 8'h44, 2'b11, 1'b1, 48'hFFFFFFFFFFFF});
    end
    checks++;
    for (int i = 0; i < 4; i++) begin
      s1 = 1'($urandom_range(0, 1)); s2 = 1'($urandom_range(0, 1));
      m1 = MW'($urandom); m2 = (i == 0) ? MW'(1) : (MW'($urandom) | MW'(1)); e = EW'($urandom);
      exp = model(s1, s2, m1, m2, 2'b11, e);
      run_op(s1, s2, m1, m2, 2'b11, e, 1'b1, lat, bok, got);
      if (got !== exp || lat != 2 * MW + 1) begin
        errors++;
        $display("FAIL div_random[%0d]: got %h lat %0d required %h lat %0d", i, got, lat, exp, 2 * MW + 1);
      end
      checks++;
    end
  endtask

  task automatic test_back_pressure();
    int lat; bit bok; logic [RW-1:0] got, exp;
    exp = model(1'b0, 1'b1, 24'h123456, 24'h654321, 2'b00, 8'h77);
    run_op(1'b0, 1'b1, 24'h123456, 24'h654321, 2'b00, 8'h77, 1'b0, lat, bok, got);
    if (got !== exp) begin
      errors++;
      $display("FAIL bp_result: got %h required %h", got, exp);
    end
    checks++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_mantissa_1 = MW'($urandom); in_operator = 2'b00;
      @(posedge clk);
      #1;
      if ({out_valid, in_ready, observed()} !== {1'b1, 1'b0, exp}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got %h required %h", i, {out_valid, in_ready, observed()}, {1'b1, 1'b0, exp});
      end
      checks++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release: got %b required 01", {out_valid, in_ready});
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    int pulses; logic [RW-1:0] exp;
    pulses = 0;
    exp = model(1'b1, 1'b1, 24'h0F0F0F, 24'h00FF00, 2'b00, 8'h22);
    @(negedge clk);
    in_valid = 1'b1; in_sign_1 = 1'b1; in_sign_2 = 1'b1; in_mantissa_1 = 24'h0F0F0F;
    in_mantissa_2 = 24'h00FF00; in_operator = 2'b00; in_exponent = 8'h22; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        pulses++;
        if (observed() !== exp) begin
          errors++;
          $display("FAIL b2b_result[%0d]: got %h required %h", i, observed(), exp);
        end
        checks++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (pulses != 5) begin
      errors++;
      $display("FAIL b2b_throughput: got %0d results required 5", pulses);
    end
    checks++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_div();
    int lat; bit bok, seen; logic [RW-1:0] got, exp;
    seen = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_sign_1 = 1'b0; in_sign_2 = 1'b1; in_mantissa_1 = 24'hC00000;
    in_mantissa_2 = 24'h300000; in_operator = 2'b11; in_exponent = 8'h99;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    if ({out_valid, in_ready, observed()} !== {1'b0, 1'b1, {RW{1'b0}}}) begin
      errors++;
      $display("FAIL rst_mid_div_async: got %h required %h", {out_valid, in_ready, observed()}, {1'b0, 1'b1, {RW{1'b0}}});
    end
    checks++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    if (seen) begin
      errors++;
      $display("FAIL rst_mid_div_no_valid: got out_valid 1 required 0");
    end
    checks++;
    exp = model(1'b0, 1'b0, 24'h400001, 24'h3FFFFF, 2'b00, 8'h01);
    run_op(1'b0, 1'b0, 24'h400001, 24'h3FFFFF, 2'b00, 8'h01, 1'b1, lat, bok, got);
    if (got !== exp || lat != 1) begin
      errors++;
      $display("FAIL rst_then_add: got %h lat %0d required %h lat 1", got, lat, exp);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_back_pressure();
    test_back_to_back();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpu_compute_iter.md
# fpu_compute_iter

Parametrised, handshaked successor to the single-cycle FPU compute stage. It sits between the exponent-align stage and the normaliser, and operates on pre-aligned sign/exponent/mantissa operands. Add and subtract complete in one cycle. Multiply uses an iterative shift-add over MAN_W cycles and divide uses restoring division over 2*MAN_W cycles, which removes the wide combinational multiplier. Valid/ready on both sides allows back-pressure from the normaliser.

## Interface
- EXP_W, 8, exponent width
- MAN_W, 24, mantissa width including hidden bit; result mantissa is 2*MAN_W
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept operands
- in_sign_1, in_sign_2  in  1 each  operand signs
- in_exponent  in  EXP_W  shared (aligned) exponent
- in_mantissa_1, in_mantissa_2  in  MAN_W each  operand mantissas
- in_operator  in  2  00 add, 01 sub, 10 mul, 11 div
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sign  out  1  result sign
- exponent  out  EXP_W  in_exponent passed through unchanged
- mantissa  out  2*MAN_W  result magnitude
- operator  out  2  in_operator passed through
- div_by_zero  out  1  set with result when op=div and in_mantissa_2=0

## Operation
- States: IDLE, MUL, DIV, DONE. in_ready = (state==IDLE), combinational.
- Accept on in_valid && in_ready. Operands, operator and exponent are captured at accept.
- Add/sub: sb = in_sign_2 ^ (op==sub).
  - sign_1==sb: mantissa = m1+m2 (zero-extended), sign = sign_1.
  - Otherwise m1>m2: m1−m2, sign_1. m2>m1: m2−m1, sb. m1==m2: 0, sign 0.
  - Next state DONE.
- Mul: sign = s1^s2. Shift-add one multiplier bit per cycle for MAN_W cycles in MUL, LSB first. Then DONE. mantissa = exact m1*m2.
- Div: sign = s1^s2. Restoring division of dividend (m1 << MAN_W) by m2, one quotient bit per cycle, 2*MAN_W cycles in DIV, MSB first. mantissa = floor((m1<<MAN_W)/m2).
- Div with m2==0: go directly to DONE. mantissa = all ones, div_by_zero=1, sign = s1^s2.
- DONE: out_valid=1. All result outputs are held stable until out_valid && out_ready, then the state returns to IDLE. No accept in the same cycle as the handoff.
- div_by_zero is 0 for every other result.

## Timing
- Reset: state IDLE; out_valid, sign, exponent, mantissa, operator, div_by_zero all 0.
- Latency from accept edge to out_valid high: add/sub 1, mul MAN_W+1, div 2*MAN_W+1, div-by-zero 1 cycle.
- Throughput: at most one operation in flight. Add/sub with out_ready held high gives one result every 2 cycles.
- Reset asserted mid-operation aborts immediately. No out_valid is produced for the aborted operation; the block is back in IDLE on release.
- Inputs are ignored while not in IDLE, and operand changes there have no effect. Result outputs must not change during DONE.

## Structure
- Shared package fpu_pkg holds:
  - operator encoding constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV)
  - the state encoding type
- One sub-module, fpu_seq_muldiv, owns the iterative datapath:
  - accumulator/remainder register, shift register, iteration counter (width clog2(2*MAN_W)+1)
  - start/mode inputs, done pulse
- The top level holds the FSM, add/sub logic, handshake and output registers.

## Test plan
- Add, MAN_W=24: m1=0xA00000, m2=0xC00000, op=00, signs 0 -> after 1 cycle mantissa=0x000001600000, sign 0, exponent unchanged.
- Sub, both orders: m1=0xAF0000, m2=0x150000, op=01 -> 0x0000009A0000, sign 0. Swapped operands -> same magnitude, sign 1. Equal operands -> 0, sign 0.
- Mul: m1=0xA00000, m2=0xC00000, op=10, s1=1 -> out_valid exactly 25 cycles after accept, mantissa=0x780000000000, sign 1, in_ready low throughout.
- Div: m1=0xC00000, m2=0x800000, op=11 -> out_valid at 49 cycles, mantissa=0x000001800000. Then m2=0 -> 1 cycle, mantissa=0xFFFFFFFFFFFF, div_by_zero=1.
- Back-pressure: out_ready low for 5 cycles after an add result -> outputs stable, in_ready low. out_ready high -> in_ready high next cycle.
- Reset mid-div: assert rst_n=0 at iteration 10 -> outputs 0 asynchronously, no out_valid. After release, a fresh add completes normally.
